// File: rtl/fp32_mult_exp_pack.sv
// -----------------------------------------------------------------------------
// fp32_mult_exp_pack
//
// Back end of the FOIL approximate FP32 multiplier. Takes the raw operands plus
// the mantissa stage's `normalised` carry and rounded 23-bit fraction. Works out
// the sign, the biased exponent and the special cases, then packs an IEEE-754
// single-precision result with exception flags.
//
// There are two register stages behind a valid/ready handshake:
//   S1 : sign, operand class bits, signed exponent, fraction
//   S2 : packed result and flags (these drive the output ports directly)
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : input handshake (transfer on in_valid & in_ready)
//   a, b              : IEEE-754 single operands
//   normalised        : product >= 2.0 from mantissa stage (exponent + 1)
//   product_mantissa  : rounded fraction, used unchanged
//   out_valid/out_ready : output handshake (transfer on out_valid & out_ready)
//   result            : packed product
//   flags             : {invalid, overflow, underflow}
// -----------------------------------------------------------------------------
module fp32_mult_exp_pack #(
    parameter int BIAS = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        normalised,
    input  logic [22:0] product_mantissa,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  flags
);

    localparam logic [9:0]  BIAS_W     = 10'(BIAS);
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam logic [2:0]  FLAG_INV   = 3'b100;
    localparam logic [2:0]  FLAG_OVF   = 3'b010;
    localparam logic [2:0]  FLAG_UNF   = 3'b001;

    // Everything the pack stage needs, captured at the input handshake.
    typedef struct packed {
        logic        sign;
        logic        any_nan;
        logic        any_inf;
        logic        any_zero;   // zero or denormal (flushed to zero)
        logic [9:0]  exp;        // two's complement, read as signed
        logic [22:0] mant;
    } s1_t;

    // ------------------------------------------------------------------
    // Handshake: each stage may advance when the stage after it can take
    // data. in_ready depends only on out_ready and the valid bits, so the
    // producer never sees a combinational loop through in_valid.
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic adv1;
    logic adv2;

    assign adv2     = ~s2_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    // ------------------------------------------------------------------
    // Input decode: operand classes, sign and the unbiased-sum exponent.
    // ------------------------------------------------------------------
    logic [7:0]  a_exp;
    logic [7:0]  b_exp;
    logic [22:0] a_frac;
    logic [22:0] b_frac;
    logic        a_zero;
    logic        b_zero;
    logic        a_inf;
    logic        b_inf;
    logic        a_nan;
    logic        b_nan;
    s1_t         s1_next;

    assign a_exp  = a[30:23];
    assign b_exp  = b[30:23];
    assign a_frac = a[22:0];
    assign b_frac = b[22:0];

    assign a_zero = (a_exp == 8'h00);
    assign b_zero = (b_exp == 8'h00);
    assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
    assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
    assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
    assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);

    // 10 bits hold every case: the sum ranges from -127 up to 384 for the
    // default bias, and wraps cleanly in two's complement below zero.
    assign s1_next.sign     = a[31] ^ b[31];
    assign s1_next.any_nan  = a_nan | b_nan;
    assign s1_next.any_inf  = a_inf | b_inf;
    assign s1_next.any_zero = a_zero | b_zero;
    assign s1_next.exp      = {2'b00, a_exp} + {2'b00, b_exp}
                            + {9'd0, normalised} - BIAS_W;
    assign s1_next.mant     = product_mantissa;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    s1_t s1_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: data registers are reset as well so nothing X-valued can leak
    // out; only the valid bits carry meaning about occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else if (adv1 && in_valid) begin
            s1_q <= s1_next;
        end
    end

    // ------------------------------------------------------------------
    // Pack: priority-ordered special cases, then the normal result.
    // ------------------------------------------------------------------
    logic signed [9:0] s1_exp;
    logic              s1_invalid;
    logic [31:0]       pack_result;
    logic [2:0]        pack_flags;

    assign s1_exp     = s1_q.exp;
    assign s1_invalid = s1_q.any_nan | (s1_q.any_inf & s1_q.any_zero);

    // NOTE: both outputs get a default before the if-chain so no path
    // leaves them unassigned, which would infer a latch.
    always_comb begin
        pack_result = {s1_q.sign, s1_exp[7:0], s1_q.mant};
        pack_flags  = 3'b000;
        if (s1_invalid) begin
            pack_result = QNAN;
            pack_flags  = FLAG_INV;
        end else if (s1_q.any_inf) begin
            pack_result = {s1_q.sign, 8'hFF, 23'd0};
        end else if (s1_q.any_zero) begin
            pack_result = {s1_q.sign, 31'd0};
        end else if (s1_exp >= 10'sd255) begin
            pack_result = {s1_q.sign, 8'hFF, 23'd0};
            pack_flags  = FLAG_OVF;
        end else if (s1_exp <= 10'sd0) begin
            // Flush to zero: no subnormal results are produced.
            pack_result = {s1_q.sign, 31'd0};
            pack_flags  = FLAG_UNF;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers; these are the output ports.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
        end
    end

    // Hold the data when S1 is empty; the contents are don't-care then and
    // holding avoids needless toggling on the output bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= 32'h0;
            flags  <= 3'b000;
        end else if (adv2 && s1_valid) begin
            result <= pack_result;
            flags  <= pack_flags;
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_fp32_mult_exp_pack.sv
// -----------------------------------------------------------------------------
// tb_fp32_mult_exp_pack
//
// Directed bench for fp32_mult_exp_pack: reset state, single-bundle latency,
// exponent boundaries, special operands, a back-to-back stream against a small
// reference model, backpressure and reset in mid-stream.
// -----------------------------------------------------------------------------
module tb_fp32_mult_exp_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        normalised = 1'b0;
    logic [22:0] product_mantissa = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [2:0]  flags;

    int tests = 0;
    int failed = 0;

    fp32_mult_exp_pack #(.BIAS(127)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .a                (a),
        .b                (b),
        .normalised       (normalised),
        .product_mantissa (product_mantissa),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .flags            (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] av, input logic [31:0] bv,
                         input logic nv, input logic [22:0] mv);
        a                = av;
        b                = bv;
        normalised       = nv;
        product_mantissa = mv;
        in_valid         = 1'b1;
    endtask

    // One bundle through an otherwise idle pipe with out_ready high.
    // Called just after a rising edge. The accepting edge loads S1, the next
    // edge loads S2, so out_valid is low after the first and high after the
    // second.
    task automatic single(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic nv, input logic [22:0] mv,
                          input logic [31:0] exp_res, input logic [2:0] exp_fl);
        drive(av, bv, nv, mv);
        #1;
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " out_valid@1"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, " out_valid@2"}, {31'd0, out_valid}, 32'd1);
        check({tag, " result"}, result, exp_res);
        check({tag, " flags"}, {29'd0, flags}, {29'd0, exp_fl});
    endtask

    logic [31:0] st_a [16];
    logic [31:0] st_b [16];
    logic        st_n [16];
    logic [22:0] st_m [16];
    logic [31:0] st_e [16];
    logic [31:0] bp_b [4];

    initial begin
        // ---------------- reset ----------------
        #2;
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst result", result, 32'h0);
        check("rst flags", {29'd0, flags}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready", {31'd0, in_ready}, 32'd1);
        check("post-rst out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // ---------------- main function ----------------
        single("2x3",       32'h4000_0000, 32'h4040_0000, 1'b0, 23'h40_0000, 32'h40C0_0000, 3'b000);
        single("1.5x1.5",   32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 23'h10_0000, 32'h4010_0000, 3'b000);
        single("neg sign",  32'hC000_0000, 32'h4040_0000, 1'b0, 23'h40_0000, 32'hC0C0_0000, 3'b000);

        // ---------------- exponent boundaries ----------------
        single("overflow",  32'h7F00_0000, 32'h7F00_0000, 1'b0, 23'h0, 32'h7F80_0000, 3'b010);
        single("underflow", 32'h0080_0000, 32'h0080_0000, 1'b0, 23'h0, 32'h0000_0000, 3'b001);
        single("e=255",     32'h5F80_0000, 32'h5F80_0000, 1'b0, 23'h0, 32'h7F80_0000, 3'b010);
        single("e=254",     32'h5F80_0000, 32'h5F00_0000, 1'b0, 23'h0, 32'h7F00_0000, 3'b000);
        single("e=0",       32'h2000_0000, 32'h1F80_0000, 1'b0, 23'h0, 32'h0000_0000, 3'b001);
        single("e=1",       32'h2000_0000, 32'h1F80_0000, 1'b1, 23'h0, 32'h0080_0000, 3'b000);

        // ---------------- special operands ----------------
        single("inf x 0",   32'h7F80_0000, 32'h0000_0000, 1'b0, 23'h0, 32'h7FC0_0000, 3'b100);
        single("-inf x 2",  32'hFF80_0000, 32'h4000_0000, 1'b0, 23'h0, 32'hFF80_0000, 3'b000);
        single("nan x 1",   32'h7FC0_0001, 32'h3F80_0000, 1'b0, 23'h0, 32'h7FC0_0000, 3'b100);
        single("denorm x 2",32'h0000_0001, 32'h4000_0000, 1'b0, 23'h0, 32'h0000_0000, 3'b000);
        single("-0 x 3",    32'h8000_0000, 32'h4040_0000, 1'b0, 23'h0, 32'h8000_0000, 3'b000);

        // ---------------- back-to-back stream ----------------
        for (int i = 0; i < 16; i++) begin
            int          ea;
            int          eb;
            int          e;
            logic        sa;
            logic        sb;
            ea = int'($urandom_range(100, 150));
            eb = int'($urandom_range(100, 150));
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            st_a[i] = {sa, 8'(ea), 23'($urandom)};
            st_b[i] = {sb, 8'(eb), 23'($urandom)};
            st_n[i] = 1'($urandom_range(0, 1));
            st_m[i] = 23'($urandom);
            e = ea + eb - 127 + int'(st_n[i]);
            st_e[i] = {sa ^ sb, 8'(e), st_m[i]};
        end
        out_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) drive(st_a[k], st_b[k], st_n[k], st_m[k]);
            else        in_valid = 1'b0;
            @(posedge clk); #1;
            if (k >= 1) begin
                check($sformatf("stream[%0d] out_valid", k - 1), {31'd0, out_valid}, 32'd1);
                check($sformatf("stream[%0d] result", k - 1), result, st_e[k - 1]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("stream drained", {31'd0, out_valid}, 32'd0);

        // ---------------- backpressure ----------------
        // 1.0 x b with b's fraction as the mantissa reproduces b exactly.
        bp_b[0] = 32'h4000_0000;
        bp_b[1] = 32'h4040_0000;
        bp_b[2] = 32'h4080_0000;
        bp_b[3] = 32'h40A0_0000;
        begin
            int          send;
            int          recv;
            int          cyc;
            logic        ir;
            logic        ov;
            logic [31:0] res;
            logic [2:0]  fl;
            send = 0;
            recv = 0;
            cyc  = 0;
            while (recv < 4 && cyc < 40) begin
                out_ready = (cyc >= 6);
                if (send < 4) drive(32'h3F80_0000, bp_b[send], 1'b0, bp_b[send][22:0]);
                else          in_valid = 1'b0;
                #1;
                ir  = in_ready;
                ov  = out_valid;
                res = result;
                fl  = flags;
                if (cyc == 2) begin
                    check("bp in_ready low", {31'd0, ir}, 32'd0);
                    check("bp accepts before stall", 32'(send), 32'd2);
                end
                if (cyc >= 2 && cyc <= 5) begin
                    check($sformatf("bp stall%0d out_valid", cyc), {31'd0, ov}, 32'd1);
                    check($sformatf("bp stall%0d result", cyc), res, bp_b[0]);
                end
                @(posedge clk); #1;
                if (ir && in_valid) send++;
                if (ov && out_ready) begin
                    check($sformatf("bp order[%0d]", recv), res, bp_b[recv]);
                    check($sformatf("bp flags[%0d]", recv), {29'd0, fl}, 32'd0);
                    recv++;
                end
                cyc++;
            end
            in_valid = 1'b0;
            check("bp all drained", 32'(recv), 32'd4);
        end
        @(posedge clk); #1;

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b0;
        drive(32'h3F80_0000, 32'h4000_0000, 1'b0, 23'h0);
        @(posedge clk); #1;
        drive(32'h3F80_0000, 32'h4040_0000, 1'b0, 23'h40_0000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full out_valid", {31'd0, out_valid}, 32'd1);
        check("full in_ready", {31'd0, in_ready}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {31'd0, out_valid}, 32'd0);
        check("async rst result", result, 32'h0);
        check("async rst flags", {29'd0, flags}, 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst release in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("no stale output", {31'd0, out_valid}, 32'd0);
        single("post-reset 2x3", 32'h4000_0000, 32'h4040_0000, 1'b0, 23'h40_0000, 32'h40C0_0000, 3'b000);
        @(posedge clk); #1;
        check("post-reset drained", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
